// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the ram_arbiter controller and its grant picker.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  // RAM rw pin encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    CLEAR
  } state_t;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way grant picker: round robin on the last-granted port, or fixed priority
// to port 0 when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_rr (
  input  logic [1:0] req,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic       last,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
`else
    // On a tie the port that was not served last goes next
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    else              grant = req;
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between two requesters and a clear command.
// Define RAM_ARB_FIXED_PRIO_EN to replace round robin with port-0 priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  input  logic              clear_req,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rw,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

  state_t           state;
  logic [1:0]       grant;
  logic             gnt_port;
  logic [CNT_W-1:0] wait_cnt;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic             last;
`endif

  ram_arb_rr u_rr (
    .req   ({req1, req0}),
`ifndef RAM_ARB_FIXED_PRIO_EN
    .last  (last),
`endif
    .grant (grant)
  );

  // The RAM pins double as the access latch: they are loaded on grant and held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt_port    <= 1'b0;
      wait_cnt    <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      clear_done  <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_rw      <= RW_READ;
      ram_reset   <= 1'b1;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last        <= 1'b1;
`endif
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      clear_done <= 1'b0;
      ram_reset  <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            ram_reset  <= 1'b1;
            clear_done <= 1'b1;
          end else if (grant != 2'b00) begin
            state       <= ISSUE;
            gnt_port    <= grant[1];
            ack0        <= grant[0];
            ack1        <= grant[1];
            ram_address <= grant[1] ? addr1 : addr0;
            ram_data_in <= grant[1] ? wdata1 : wdata0;
            ram_rw      <= grant[1] ? rw1 : rw0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last        <= grant[1];
`endif
          end
        end
        ISSUE: begin
          ram_data_in <= '0;
          if (ram_rw == RW_READ) begin
            state    <= WAIT_RD;
            wait_cnt <= CNT_INIT;
          end else begin
            state  <= IDLE;
            ram_rw <= RW_READ;
          end
        end
        WAIT_RD: begin
          if (wait_cnt == '0) begin
            state <= IDLE;
            if (gnt_port) begin
              rdata1  <= ram_data_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= ram_data_out;
              rvalid0 <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
